multicore_boot_loader: RTL and testbench
========================================

# multicore_boot_loader

Parametrised boot-image loader for the multi-core RISC-V SoC. It runs at run time the init flow that simulation does today with file loads. It takes a word stream (header, payload, optional checksum) and writes per-core instruction and scalar images into the shared dual-port ROM. Cores are held in reset until their images are loaded and an explicit release command arrives. It sits between the host/debug stream interface and the ROM write port and drives each core's reset.

## Interface
- NUM_CORES, 2, number of cores (1..16)
- INSTR_DEPTH, 1024, instruction words per core
- SCALAR_DEPTH, 1024, scalar-data words per core
- ROM_AW, $clog2(NUM_CORES*(INSTR_DEPTH+SCALAR_DEPTH)), ROM word-address width (derived)

- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-high reset
- s_valid  in  1  stream word valid
- s_ready  out  1  stream word accepted when s_valid&&s_ready
- s_data  in  32  stream word
- rom_we  out  1  ROM write strobe
- rom_addr  out  ROM_AW  ROM word address
- rom_wdata  out  32  ROM write data
- core_rst  out  NUM_CORES  per-core reset, 1 = held
- loaded_instr  out  NUM_CORES  instruction image complete
- loaded_scalar  out  NUM_CORES  scalar image complete
- busy  out  1  loader not in IDLE
- err_valid  out  1  one-cycle error pulse
- err_code  out  3  last error, sticky until next error or reset

## Operation
- Address map:
  - Instruction region of core k at k*INSTR_DEPTH.
  - Scalar region of core k at NUM_CORES*INSTR_DEPTH + k*SCALAR_DEPTH.
  - With default parameters: core0 instr 0, core1 instr 1024, core0 scalar 2048, core1 scalar 3072.
- Load header: [31:24]=0xB0, [23:16]=core id, [15]=region (0 instr, 1 scalar), [14:0]=count N.
- Release header: [31:24]=0xB1, [15:0]=core mask. Mask bits at or above NUM_CORES are ignored.
- States:
  - IDLE: waits for a header.
  - LOAD: accepts N payload words and writes them to ROM at base, base+1, …, base+N-1.
  - CKSUM: accepts one word and compares it with the XOR of the payload (macro only).
  - DRAIN: accepts and discards N words, with no ROM writes.
- Transitions:
  - IDLE→LOAD on a valid load header.
  - LOAD→CKSUM (macro) or →IDLE after word N.
  - CKSUM→IDLE.
  - IDLE→DRAIN on a rejected load header with N≥1.
  - DRAIN→IDLE after word N.
- Error codes:
  - 1: unknown magic. Word discarded, stay in IDLE.
  - 2: core id ≥ NUM_CORES, or N=0, or N > region depth. Go to DRAIN (stay in IDLE if N=0).
  - 3: load targets a core whose core_rst=0. Go to DRAIN.
  - 4: checksum mismatch. Loaded bit not set; words already written stay in ROM.
  - 5: release of a core whose loaded_instr=0. That core stays held; other valid mask bits still release.
- Loaded bits:
  - The region's loaded bit clears on acceptance of a valid load header.
  - It sets on successful completion.
- Release only clears core_rst bits. Nothing re-asserts them except rst.
- s_ready is 1 in every state out of reset. The block never back-pressures except during reset.

## Timing
- Reset values: s_ready=0, rom_we=0, rom_addr=0, rom_wdata=0, core_rst=all 1, loaded_*=0, busy=0, err_valid=0, err_code=0, state IDLE.
- s_ready rises the first cycle after rst deasserts.
- ROM writes are registered: a payload word accepted in cycle t gives rom_we=1 with its address and data in cycle t+1. Back-to-back payload at one word per cycle gives back-to-back writes.
- loaded_* sets in the cycle after the last payload word (no macro) or after the checksum word (macro).
- core_rst bits clear in the cycle after the release header is accepted.
- err_valid pulses in the cycle after the offending word; err_code updates in the same cycle.
- rst asserted mid-load aborts immediately:
  - No further ROM writes.
  - All cores held, loaded bits cleared.
  - ROM contents are not touched.

## Configuration
- BOOT_CKSUM_EN defined:
  - Each load is followed by a 32-bit XOR checksum word; the CKSUM state exists.
  - Error 4 is possible.
- Undefined:
  - No checksum word; LOAD returns directly to IDLE.
  - Error 4 is never raised.

## Test plan
All cases use defaults with BOOT_CKSUM_EN defined.
- Core0 instr load: 0xB0000003, 0x11, 0x22, 0x33, 0x00 → ROM writes at addr 0/1/2 with data 0x11/0x22/0x33; loaded_instr=2'b01; no error.
- Core1 scalar load: 0xB0018002, 0xA, 0x5, 0xF → writes at 3072 and 3073; loaded_scalar=2'b10.
- Release before load then after:
  - 0xB1000003 with only core0 loaded → core_rst=2'b10, err_code=5.
  - Load core1 instr, then 0xB1000002 → core_rst=2'b00.
- Bad checksum: 0xB0000001, 0x7, 0x6 → one ROM write, err_code=4, loaded_instr[0]=0.
- Rejected headers:
  - 0xB0020002 (core 2) or 0xB0000401 (N=1025) → err_code=2; the stated number of words is drained with no rom_we; the next valid header loads normally.
  - 0xC0000000 → err_code=1, stay in IDLE.
- Reset mid-load: assert rst after 2 of 3 payload words → rom_we=0 from assertion, core_rst=all 1, loaded_*=0; a fresh load completes afterwards.

Source files
------------

// File: rtl/multicore_boot_loader.sv
// Boot-image loader: header/payload word stream -> registered ROM writes (1-cycle latency), per-core reset release.
// Never back-pressures out of reset. Optional trailing XOR checksum per load under `BOOT_CKSUM_EN.
module multicore_boot_loader #(
   parameter int NUM_CORES    = 2,
   parameter int INSTR_DEPTH  = 1024,
   parameter int SCALAR_DEPTH = 1024,
   parameter int ROM_AW       = $clog2(NUM_CORES*(INSTR_DEPTH+SCALAR_DEPTH))
)(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 s_valid,
   output logic                 s_ready,
   input  logic [31:0]          s_data,
   output logic                 rom_we,
   output logic [ROM_AW-1:0]    rom_addr,
   output logic [31:0]          rom_wdata,
   output logic [NUM_CORES-1:0] core_rst,
   output logic [NUM_CORES-1:0] loaded_instr,
   output logic [NUM_CORES-1:0] loaded_scalar,
   output logic                 busy,
   output logic                 err_valid,
   output logic [2:0]           err_code
);
   typedef enum logic [1:0] {IDLE, LOAD, CKSUM, DRAIN} state_t;

   state_t                state, state_nx;
   logic [14:0]           cnt, cnt_nx;
   logic [ROM_AW-1:0]     addr, addr_nx;
   logic [7:0]            cur_core, cur_core_nx;
   logic                  cur_reg, cur_reg_nx;
   logic                  rom_we_nx;
   logic [ROM_AW-1:0]     rom_addr_nx;
   logic [31:0]           rom_wdata_nx;
   logic [NUM_CORES-1:0]  core_rst_nx, loaded_instr_nx, loaded_scalar_nx;
   logic                  err_valid_nx;
   logic [2:0]            err_code_nx;
`ifdef BOOT_CKSUM_EN
   logic [31:0]           xsum, xsum_nx;
`endif

   logic                  accept;
   logic [7:0]            hdr_core;
   logic                  hdr_reg;
   logic [14:0]           hdr_n;
   logic                  core_ok, len_ok, held;
   int                    depth;
   logic [ROM_AW-1:0]     base;

   assign accept   = s_valid && s_ready;
   assign hdr_core = s_data[23:16];
   assign hdr_reg  = s_data[15];
   assign hdr_n    = s_data[14:0];
   assign busy     = (state != IDLE);

   always_comb begin
      depth   = hdr_reg ? SCALAR_DEPTH : INSTR_DEPTH;
      core_ok = 32'(hdr_core) < NUM_CORES;
      len_ok  = (hdr_n != 15'd0) && (32'(hdr_n) <= depth);
      held    = 1'b0;
      for (int k = 0; k < NUM_CORES; k++)
         if (hdr_core == 8'(k)) held = core_rst[k];
      base = hdr_reg ? ROM_AW'(NUM_CORES*INSTR_DEPTH + 32'(hdr_core)*SCALAR_DEPTH)
                     : ROM_AW'(32'(hdr_core)*INSTR_DEPTH);
   end

   always_comb begin
      state_nx         = state;
      cnt_nx           = cnt;
      addr_nx          = addr;
      cur_core_nx      = cur_core;
      cur_reg_nx       = cur_reg;
      rom_we_nx        = 1'b0;
      rom_addr_nx      = rom_addr;
      rom_wdata_nx     = rom_wdata;
      core_rst_nx      = core_rst;
      loaded_instr_nx  = loaded_instr;
      loaded_scalar_nx = loaded_scalar;
      err_valid_nx     = 1'b0;
      err_code_nx      = err_code;
`ifdef BOOT_CKSUM_EN
      xsum_nx          = xsum;
`endif
      if (accept) begin
         case (state)
            IDLE: begin
               if (s_data[31:24] == 8'hB0) begin
                  cnt_nx = hdr_n;
                  if (!core_ok || !len_ok) begin
                     err_valid_nx = 1'b1;
                     err_code_nx  = 3'd2;
                     if (hdr_n != 15'd0) state_nx = DRAIN;
                  end else if (!held) begin
                     err_valid_nx = 1'b1;
                     err_code_nx  = 3'd3;
                     state_nx     = DRAIN;
                  end else begin
                     state_nx    = LOAD;
                     addr_nx     = base;
                     cur_core_nx = hdr_core;
                     cur_reg_nx  = hdr_reg;
`ifdef BOOT_CKSUM_EN
                     xsum_nx     = 32'd0;
`endif
                     for (int k = 0; k < NUM_CORES; k++)
                        if (hdr_core == 8'(k)) begin
                           if (hdr_reg) loaded_scalar_nx[k] = 1'b0;
                           else         loaded_instr_nx[k]  = 1'b0;
                        end
                  end
               end else if (s_data[31:24] == 8'hB1) begin
                  // mask bits beyond NUM_CORES are simply never looked at
                  for (int k = 0; k < NUM_CORES; k++)
                     if (s_data[k]) begin
                        if (loaded_instr[k]) core_rst_nx[k] = 1'b0;
                        else begin
                           err_valid_nx = 1'b1;
                           err_code_nx  = 3'd5;
                        end
                     end
               end else begin
                  err_valid_nx = 1'b1;
                  err_code_nx  = 3'd1;
               end
            end
            LOAD: begin
               rom_we_nx    = 1'b1;
               rom_addr_nx  = addr;
               rom_wdata_nx = s_data;
               addr_nx      = addr + ROM_AW'(1);
               cnt_nx       = cnt - 15'd1;
`ifdef BOOT_CKSUM_EN
               xsum_nx      = xsum ^ s_data;
               if (cnt == 15'd1) state_nx = CKSUM;
`else
               if (cnt == 15'd1) begin
                  state_nx = IDLE;
                  for (int k = 0; k < NUM_CORES; k++)
                     if (cur_core == 8'(k)) begin
                        if (cur_reg) loaded_scalar_nx[k] = 1'b1;
                        else         loaded_instr_nx[k]  = 1'b1;
                     end
               end
`endif
            end
`ifdef BOOT_CKSUM_EN
            CKSUM: begin
               state_nx = IDLE;
               if (s_data == xsum) begin
                  for (int k = 0; k < NUM_CORES; k++)
                     if (cur_core == 8'(k)) begin
                        if (cur_reg) loaded_scalar_nx[k] = 1'b1;
                        else         loaded_instr_nx[k]  = 1'b1;
                     end
               end else begin
                  err_valid_nx = 1'b1;
                  err_code_nx  = 3'd4;
               end
            end
`endif
            DRAIN: begin
               cnt_nx = cnt - 15'd1;
               if (cnt == 15'd1) state_nx = IDLE;
            end
            default: state_nx = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         cnt           <= '0;
         addr          <= '0;
         cur_core      <= '0;
         cur_reg       <= 1'b0;
         s_ready       <= 1'b0;
         rom_we        <= 1'b0;
         rom_addr      <= '0;
         rom_wdata     <= '0;
         core_rst      <= '1;
         loaded_instr  <= '0;
         loaded_scalar <= '0;
         err_valid     <= 1'b0;
         err_code      <= 3'd0;
`ifdef BOOT_CKSUM_EN
         xsum          <= '0;
`endif
      end else begin
         state         <= state_nx;
         cnt           <= cnt_nx;
         addr          <= addr_nx;
         cur_core      <= cur_core_nx;
         cur_reg       <= cur_reg_nx;
         s_ready       <= 1'b1;
         rom_we        <= rom_we_nx;
         rom_addr      <= rom_addr_nx;
         rom_wdata     <= rom_wdata_nx;
         core_rst      <= core_rst_nx;
         loaded_instr  <= loaded_instr_nx;
         loaded_scalar <= loaded_scalar_nx;
         err_valid     <= err_valid_nx;
         err_code      <= err_code_nx;
`ifdef BOOT_CKSUM_EN
         xsum          <= xsum_nx;
`endif
      end
   end
endmodule

// File: tb/tb_multicore_boot_loader.sv
// Directed bench for multicore_boot_loader (default parameters); follows `BOOT_CKSUM_EN if defined.
module tb_multicore_boot_loader;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        s_valid = 1'b0;
   logic        s_ready;
   logic [31:0] s_data = 32'd0;
   logic        rom_we;
   logic [11:0] rom_addr;
   logic [31:0] rom_wdata;
   logic [1:0]  core_rst, loaded_instr, loaded_scalar;
   logic        busy, err_valid;
   logic [2:0]  err_code;

   int errors = 0;
   int checks = 0;
   int we_seen;

   multicore_boot_loader dut (
      .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .rom_we(rom_we), .rom_addr(rom_addr), .rom_wdata(rom_wdata),
      .core_rst(core_rst), .loaded_instr(loaded_instr), .loaded_scalar(loaded_scalar),
      .busy(busy), .err_valid(err_valid), .err_code(err_code)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // drive one word for one cycle; returns 1 time unit after the accepting edge
   task automatic send(input logic [31:0] w);
      s_valid = 1'b1;
      s_data  = w;
      @(posedge clk);
      #1;
      s_valid = 1'b0;
   endtask

   task automatic send_ck(input logic [31:0] w);
`ifdef BOOT_CKSUM_EN
      send(w);
`else
      if (w == 32'hFFFF_FFFF) $display("unused checksum word");
`endif
   endtask

   task automatic check_write(input string tag, input logic [11:0] a, input logic [31:0] d);
      check({tag, "_we"},   32'(rom_we), 32'd1);
      check({tag, "_addr"}, 32'(rom_addr), 32'(a));
      check({tag, "_data"}, rom_wdata, d);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check("rst_s_ready", 32'(s_ready), 32'd0);
      check("rst_rom_we", 32'(rom_we), 32'd0);
      check("rst_rom_addr", 32'(rom_addr), 32'd0);
      check("rst_core_rst", 32'(core_rst), 32'd3);
      check("rst_loaded", 32'({loaded_instr, loaded_scalar}), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_err", 32'({err_valid, err_code}), 32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("s_ready_rise", 32'(s_ready), 32'd1);

      // core0 instruction image
      send(32'hB000_0003);
      check("t1_busy", 32'(busy), 32'd1);
      check("t1_hdr_no_we", 32'(rom_we), 32'd0);
      send(32'h11); check_write("t1_w0", 12'd0, 32'h11);
      send(32'h22); check_write("t1_w1", 12'd1, 32'h22);
      send(32'h33); check_write("t1_w2", 12'd2, 32'h33);
      send_ck(32'h00);
      check("t1_loaded_instr", 32'(loaded_instr), 32'd1);
      check("t1_no_err", 32'({err_valid, err_code}), 32'd0);
      check("t1_idle", 32'(busy), 32'd0);

      // core1 scalar image
      send(32'hB001_8002);
      send(32'hA); check_write("t2_w0", 12'd3072, 32'hA);
      send(32'h5); check_write("t2_w1", 12'd3073, 32'h5);
      send_ck(32'hF);
      check("t2_loaded_scalar", 32'(loaded_scalar), 32'd2);

`ifdef BOOT_CKSUM_EN
      // checksum mismatch on core0 instruction reload
      send(32'hB000_0001);
      check("t3_loaded_cleared", 32'(loaded_instr), 32'd0);
      send(32'h7); check_write("t3_w0", 12'd0, 32'h7);
      send(32'h6);
      check("t3_err_valid", 32'(err_valid), 32'd1);
      check("t3_err_code", 32'(err_code), 32'd4);
      check("t3_loaded_instr", 32'(loaded_instr), 32'd0);
      check("t3_no_we", 32'(rom_we), 32'd0);
`endif

      // core id out of range: two words drained
      send(32'hB002_0002);
      check("t4_err_valid", 32'(err_valid), 32'd1);
      check("t4_err_code", 32'(err_code), 32'd2);
      check("t4_busy", 32'(busy), 32'd1);
      send(32'hB000_0001);
      check("t4_drain0_we", 32'(rom_we), 32'd0);
      check("t4_drain0_busy", 32'(busy), 32'd1);
      send(32'h1234_5678);
      check("t4_drain1_we", 32'(rom_we), 32'd0);
      check("t4_drain_done", 32'(busy), 32'd0);

      // N above region depth: 1025 words drained
      send(32'hB000_0401);
      check("t5_err_code", 32'(err_code), 32'd2);
      check("t5_err_valid", 32'(err_valid), 32'd1);
      we_seen = 0;
      for (int i = 0; i < 1025; i++) begin
         send(32'(i));
         we_seen += int'(rom_we);
         if (i == 1023) check("t5_busy_1024", 32'(busy), 32'd1);
      end
      check("t5_no_writes", 32'(we_seen), 32'd0);
      check("t5_done", 32'(busy), 32'd0);
      send(32'hB000_0001);
      send(32'h11); check_write("t5_reload", 12'd0, 32'h11);
      send_ck(32'h11);
      check("t5_loaded_instr", 32'(loaded_instr), 32'd1);

      // N = 0 stays idle
      send(32'hB000_0000);
      check("t6_err_code", 32'(err_code), 32'd2);
      check("t6_idle", 32'(busy), 32'd0);

      // unknown magic
      send(32'hC000_0000);
      check("t7_err_valid", 32'(err_valid), 32'd1);
      check("t7_err_code", 32'(err_code), 32'd1);
      check("t7_idle", 32'(busy), 32'd0);

      // release with only core0 loaded
      send(32'hB100_0003);
      check("t8_core_rst", 32'(core_rst), 32'd2);
      check("t8_err_valid", 32'(err_valid), 32'd1);
      check("t8_err_code", 32'(err_code), 32'd5);
      @(posedge clk);
      #1;
      check("t8_pulse_end", 32'(err_valid), 32'd0);
      check("t8_sticky", 32'(err_code), 32'd5);

      // load core1 instr, then release it
      send(32'hB001_0001);
      send(32'h44); check_write("t9_w0", 12'd1024, 32'h44);
      send_ck(32'h44);
      check("t9_loaded_instr", 32'(loaded_instr), 32'd3);
      send(32'hB100_0002);
      check("t9_core_rst", 32'(core_rst), 32'd0);
      check("t9_no_err", 32'(err_valid), 32'd0);

      // load to a released core
      send(32'hB000_0002);
      check("t10_err_code", 32'(err_code), 32'd3);
      check("t10_busy", 32'(busy), 32'd1);
      send(32'h1); check("t10_d0_we", 32'(rom_we), 32'd0);
      send(32'h2); check("t10_d1_we", 32'(rom_we), 32'd0);
      check("t10_done", 32'(busy), 32'd0);

      // reset mid-load
      rst = 1'b1;
      #2;
      rst = 1'b0;
      @(posedge clk);
      #1;
      send(32'hB000_0003);
      send(32'hAA);
      send(32'hBB); check_write("t11_w1", 12'd1, 32'hBB);
      rst = 1'b1;
      #1;
      check("t11_we_abort", 32'(rom_we), 32'd0);
      check("t11_core_rst", 32'(core_rst), 32'd3);
      check("t11_loaded", 32'({loaded_instr, loaded_scalar}), 32'd0);
      check("t11_busy", 32'(busy), 32'd0);
      @(posedge clk);
      #1;
      check("t11_we_held", 32'(rom_we), 32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;
      send(32'hB000_0001);
      send(32'h55); check_write("t11_fresh", 12'd0, 32'h55);
      send_ck(32'h55);
      check("t11_fresh_loaded", 32'(loaded_instr), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
